// File: rtl/fpga_template_pkg.sv
// Shared types and defaults for the microphone capture sequencer.
// Holds the capture FSM encoding and the default sample/depth sizes.
package fpga_template_pkg;

  localparam int MIC_SAMPLE_W  = 24;
  localparam int MIC_CAP_DEPTH = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WR_L,
    ST_WR_R,
    ST_DONE
  } capture_state_t;

endpackage

// File: rtl/mic_capture_seq.sv
// Sequences I2S sample strobes into an external sample RAM.
// Define MIC_CAPTURE_STEREO_EN to store L/R pairs; default stores left only.
module mic_capture_seq
  import fpga_template_pkg::*;
#(
  parameter int  DEPTH_FRAMES = MIC_CAP_DEPTH,
  parameter int  SAMPLE_W     = MIC_SAMPLE_W,
  localparam int CW           = $clog2(DEPTH_FRAMES) + 1,
  localparam int AW           = $clog2(2 * DEPTH_FRAMES)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [CW-1:0]       num_frames_i,
  input  logic                sample_stb_i,
  input  logic [SAMPLE_W-1:0] left_i,
  input  logic [SAMPLE_W-1:0] right_i,
  output logic                mem_we_o,
  output logic [AW-1:0]       mem_addr_o,
  output logic [SAMPLE_W-1:0] mem_wdata_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o,
  output logic [CW-1:0]       frames_o
);

  capture_state_t      state_q;
  logic [CW-1:0]       frames_q;
  logic [CW-1:0]       target_q;
  logic                we_q;
  logic                done_q;
  logic                overrun_q;
  logic [AW-1:0]       addr_q;
  logic [SAMPLE_W-1:0] wdata_q;

  logic [CW-1:0]       req_frames;
  logic [CW-1:0]       frames_inc;
  logic                last_frame;
  logic [AW-1:0]       base_addr;
  logic                aborting;

  assign req_frames = (num_frames_i > CW'(DEPTH_FRAMES))
                    ? CW'(DEPTH_FRAMES) : num_frames_i;
  assign frames_inc = frames_q + CW'(1);
  assign last_frame = (frames_inc == target_q);
  assign aborting   = abort_i && (state_q != ST_IDLE);

`ifdef MIC_CAPTURE_STEREO_EN
  logic [SAMPLE_W-1:0] right_q;
  assign base_addr = AW'({frames_q, 1'b0});
`else
  logic unused_right;
  assign unused_right = ^right_i;
  assign base_addr    = AW'(frames_q);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      frames_q  <= '0;
      target_q  <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef MIC_CAPTURE_STEREO_EN
      right_q   <= '0;
`endif
    end else if (aborting) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          if (start_i && (num_frames_i != '0)) begin
            frames_q  <= '0;
            overrun_q <= 1'b0;
            target_q  <= req_frames;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sample_stb_i) begin
            we_q    <= 1'b1;
            addr_q  <= base_addr;
            wdata_q <= left_i;
`ifdef MIC_CAPTURE_STEREO_EN
            right_q <= right_i;
`endif
            state_q <= ST_WR_L;
          end
        end
`ifdef MIC_CAPTURE_STEREO_EN
        ST_WR_L: begin
          if (sample_stb_i) overrun_q <= 1'b1;
          addr_q  <= base_addr + AW'(1);
          wdata_q <= right_q;
          state_q <= ST_WR_R;
        end
        ST_WR_R: begin
          if (sample_stb_i) overrun_q <= 1'b1;
          we_q     <= 1'b0;
          frames_q <= frames_inc;
          done_q   <= last_frame;
          state_q  <= last_frame ? ST_DONE : ST_WAIT;
        end
`else
        ST_WR_L: begin
          if (sample_stb_i) overrun_q <= 1'b1;
          we_q     <= 1'b0;
          frames_q <= frames_inc;
          done_q   <= last_frame;
          state_q  <= last_frame ? ST_DONE : ST_WAIT;
        end
`endif
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Abort suppresses the write or done pulse already on the outputs.
  assign mem_we_o    = we_q & ~aborting;
  assign done_o      = done_q & ~aborting;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign overrun_o   = overrun_q;
  assign frames_o    = frames_q;

endmodule

// File: tb/tb_mic_capture_seq.sv
// Self-checking bench for mic_capture_seq (random data and gaps).
// Expected RAM images come from a frame-list model, not the FSM.
module tb_mic_capture_seq;

  localparam int D  = 256;
  localparam int SW = 24;
  localparam int CW = $clog2(D) + 1;
  localparam int AW = $clog2(2 * D);
`ifdef MIC_CAPTURE_STEREO_EN
  localparam int WPF = 2;
`else
  localparam int WPF = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] num_frames = '0;
  logic          stb = 1'b0;
  logic [SW-1:0] left = '0;
  logic [SW-1:0] right = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          overrun;
  logic [CW-1:0] frames;

  mic_capture_seq #(.DEPTH_FRAMES(D), .SAMPLE_W(SW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .abort_i(abort),
    .num_frames_i(num_frames), .sample_stb_i(stb),
    .left_i(left), .right_i(right),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .busy_o(busy), .done_o(done), .overrun_o(overrun), .frames_o(frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [SW-1:0] d;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0;
  int  last_we_cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  checks = 0;
  int  passed = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_we === 1'b1) begin
      wq.push_back('{mem_addr, mem_wdata});
      last_we_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n);
    num_frames = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic strobe(input logic [SW-1:0] l, input logic [SW-1:0] r);
    left = l;
    right = r;
    stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  // Expected RAM image: frame k lands at k (mono) or 2k/2k+1 (stereo).
  task automatic model_frames(input logic [SW-1:0] ls[$],
                              input logic [SW-1:0] rs[$],
                              output wr_t exp[$]);
    exp.delete();
    foreach (ls[k]) begin
      exp.push_back('{AW'(k * WPF), ls[k]});
      if (WPF == 2) exp.push_back('{AW'(k * WPF + 1), rs[k]});
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    tick(3);
    checks++;
    if ({mem_we, mem_addr, mem_wdata, busy, done, overrun, frames} !== '0)
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h busy=%b done=%b ovr=%b frames=%0d want all 0",
               mem_we, mem_addr, mem_wdata, busy, done, overrun, frames);
    else passed++;
    rst_ni = 1'b1;
    tick(2);
  endtask

  // Runs n requested frames with random data and gaps, checks the RAM image.
  task automatic test_capture(input string nm, input int n, input bit fixed);
    logic [SW-1:0] ls[$];
    logic [SW-1:0] rs[$];
    wr_t exp[$];
    int  base, dbase, eff;
    bit  ok;
    eff = (n > D) ? D : n;
    base = wq.size();
    dbase = done_cnt;
    pulse_start(n);
    checks++;
    if (busy !== 1'b1) $display("FAIL %s_busy: got %b want 1", nm, busy);
    else passed++;
    for (int k = 0; k < eff; k++) begin
      logic [SW-1:0] l, r;
      l = fixed ? SW'(32'h00000A + k) : SW'($urandom);
      r = fixed ? SW'(32'h0B0000 + k) : SW'($urandom);
      ls.push_back(l);
      rs.push_back(r);
      strobe(l, r);
      if (k == 0) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== '0 || mem_wdata !== l)
          $display("FAIL %s_left_latency: got we=%b addr=%h data=%h want 1/0/%h",
                   nm, mem_we, mem_addr, mem_wdata, l);
        else passed++;
        if (WPF == 2) begin
          tick();
          checks++;
          if (mem_we !== 1'b1 || mem_addr !== AW'(1) || mem_wdata !== r)
            $display("FAIL %s_right_latency: got we=%b addr=%h data=%h want 1/1/%h",
                     nm, mem_we, mem_addr, mem_wdata, r);
          else passed++;
          tick();
        end else tick();
      end else tick(WPF);
      if (eff < 20) tick($urandom_range(0, 3));
    end
    wait_idle(10, ok);
    checks++;
    if (!ok) $display("FAIL %s_timeout: busy=%b want 0", nm, busy);
    else passed++;
    model_frames(ls, rs, exp);
    checks++;
    if (wq.size() - base != exp.size())
      $display("FAIL %s_write_count: got %0d want %0d", nm, wq.size() - base, exp.size());
    else passed++;
    begin
      int bad;
      bad = 0;
      foreach (exp[i])
        if (base + i < wq.size())
          if (wq[base + i].a !== exp[i].a || wq[base + i].d !== exp[i].d) begin
            if (bad == 0)
              $display("FAIL %s_write_%0d: got %h:%h want %h:%h", nm, i,
                       wq[base + i].a, wq[base + i].d, exp[i].a, exp[i].d);
            bad++;
          end
      checks++;
      if (bad != 0) $display("FAIL %s_image: %0d bad writes want 0", nm, bad);
      else passed++;
    end
    checks++;
    if (frames !== CW'(eff)) $display("FAIL %s_frames: got %0d want %0d", nm, frames, eff);
    else passed++;
    checks++;
    if (done_cnt - dbase != 1 || done_cyc != last_we_cyc + 1)
      $display("FAIL %s_done: got %0d pulses at cyc %0d want 1 at %0d",
               nm, done_cnt - dbase, done_cyc, last_we_cyc + 1);
    else passed++;
    if (n > D) begin
      checks++;
      if (wq[wq.size() - 1].a !== AW'(D * WPF - 1))
        $display("FAIL %s_last_addr: got %0d want %0d", nm, wq[wq.size() - 1].a, D * WPF - 1);
      else passed++;
    end
    tick(2);
  endtask

  task automatic test_zero_frames;
    int base, dbase;
    base = wq.size();
    dbase = done_cnt;
    pulse_start(0);
    checks++;
    if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy);
    else passed++;
    stb = 1'b1;
    tick(3);
    stb = 1'b0;
    tick(2);
    checks++;
    if (wq.size() != base || done_cnt != dbase || busy !== 1'b0)
      $display("FAIL zero_activity: got %0d writes %0d dones busy=%b want 0 0 0",
               wq.size() - base, done_cnt - dbase, busy);
    else passed++;
  endtask

  task automatic test_abort;
    logic [SW-1:0] l0, r0;
    int base, dbase;
    base = wq.size();
    dbase = done_cnt;
    l0 = SW'($urandom);
    r0 = SW'($urandom);
    pulse_start(3);
    strobe(l0, r0);
    tick(WPF + 1);
    abort = 1'b1;
    strobe(SW'($urandom), SW'($urandom));
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL abort_idle: got busy=%b we=%b want 0 0", busy, mem_we);
    else passed++;
    tick(4);
    checks++;
    if (wq.size() - base != WPF || frames !== CW'(1) || done_cnt != dbase)
      $display("FAIL abort_result: got %0d writes frames=%0d dones=%0d want %0d 1 0",
               wq.size() - base, frames, done_cnt - dbase, WPF);
    else passed++;
    checks++;
    if (wq[base].a !== '0 || wq[base].d !== l0)
      $display("FAIL abort_frame0: got %h:%h want 0:%h", wq[base].a, wq[base].d, l0);
    else passed++;
  endtask

  task automatic test_overrun;
    logic [SW-1:0] la, ra, lc, rc;
    int base;
    bit ok;
    base = wq.size();
    la = SW'($urandom); ra = SW'($urandom);
    lc = SW'($urandom); rc = SW'($urandom);
    pulse_start(2);
    strobe(la, ra);
    strobe(SW'($urandom), SW'($urandom));
    checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun);
    else passed++;
    tick(2);
    strobe(lc, rc);
    wait_idle(10, ok);
    checks++;
    if (!ok || wq.size() - base != 2 * WPF)
      $display("FAIL overrun_writes: got %0d want %0d", wq.size() - base, 2 * WPF);
    else passed++;
    checks++;
    if (wq[base + WPF].a !== AW'(WPF) || wq[base + WPF].d !== lc || overrun !== 1'b1)
      $display("FAIL overrun_drop: got %h:%h ovr=%b want %h:%h ovr=1",
               wq[base + WPF].a, wq[base + WPF].d, overrun, AW'(WPF), lc);
    else passed++;
    pulse_start(1);
    checks++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b want 0", overrun);
    else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    logic [SW-1:0] l;
    int base;
    bit ok;
    pulse_start(4);
    strobe(SW'($urandom), SW'($urandom));
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, busy, done, overrun, frames} !== '0)
      $display("FAIL reset_mid: got we=%b addr=%h busy=%b frames=%0d want all 0",
               mem_we, mem_addr, busy, frames);
    else passed++;
    tick(2);
    rst_ni = 1'b1;
    tick(2);
    base = wq.size();
    l = SW'($urandom);
    pulse_start(1);
    strobe(l, SW'($urandom));
    wait_idle(10, ok);
    checks++;
    if (!ok || wq.size() - base != WPF || wq[base].a !== '0 || wq[base].d !== l || frames !== CW'(1))
      $display("FAIL reset_restart: got %0d writes first=%h:%h frames=%0d want %0d 0:%h 1",
               wq.size() - base, wq[base].a, wq[base].d, frames, WPF, l);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_capture("basic", 4, 1'b1);
    test_zero_frames();
    for (int t = 0; t < 3; t++)
      test_capture($sformatf("rand%0d", t), $urandom_range(1, 12), 1'b0);
    test_abort();
    test_overrun();
    test_capture("clamp", 300, 1'b0);
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
